// File: rtl/sram_dual_xbar_sync.sv
// Registered 2x2 crossbar between two masters (A, B) and two SRAM controllers (1, 2).
// Each channel remembers which master owns its in-flight transaction, so a
// later mapping change can never misroute a completion. Mapping changes are
// deferred until both channels are idle and no request is arriving.
module sram_dual_xbar_sync #(
    parameter int DW = 16,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,
    output logic          map_o,
    output logic          swap_ack,
    input  logic          i_mem_A,
    input  logic          i_mem_B,
    input  logic          i_rw_A,
    input  logic          i_rw_B,
    input  logic [DW-1:0] i_din_A,
    input  logic [DW-1:0] i_din_B,
    input  logic [AW-1:0] i_adr_A,
    input  logic [AW-1:0] i_adr_B,
    output logic          o_ready_A,
    output logic          o_ready_B,
    output logic [DW-1:0] o_dout_A,
    output logic [DW-1:0] o_dout_B,
    output logic          o_mem1,
    output logic          o_mem2,
    output logic          o_rw1,
    output logic          o_rw2,
    output logic [DW-1:0] o_din1,
    output logic [DW-1:0] o_din2,
    output logic [AW-1:0] o_adr1,
    output logic [AW-1:0] o_adr2,
    input  logic          i_ready1,
    input  logic          i_ready2,
    input  logic [DW-1:0] i_dout1,
    input  logic [DW-1:0] i_dout2,
    output logic          err_o
);

    typedef enum logic {SW_STABLE, SW_PENDING} swap_state_t;

    // Master index 0 = A, 1 = B; channel index 0 = controller 1, 1 = controller 2.
    logic [1:0]    m_mem;
    logic [1:0]    m_rw;
    logic [DW-1:0] m_din [2];
    logic [AW-1:0] m_adr [2];
    logic [1:0]    c_ready;
    logic [DW-1:0] c_dout [2];

    assign m_mem    = {i_mem_B, i_mem_A};
    assign m_rw     = {i_rw_B, i_rw_A};
    assign m_din[0] = i_din_A;
    assign m_din[1] = i_din_B;
    assign m_adr[0] = i_adr_A;
    assign m_adr[1] = i_adr_B;
    assign c_ready  = {i_ready2, i_ready1};
    assign c_dout[0] = i_dout1;
    assign c_dout[1] = i_dout2;

    logic          map_reg;
    logic [1:0]    busy_reg;
    logic [1:0]    owner_reg;
    logic [1:0]    mem_out_reg;
    logic [1:0]    rw_out_reg;
    logic [DW-1:0] din_out_reg [2];
    logic [AW-1:0] adr_out_reg [2];
    logic [1:0]    ready_out_reg;
    logic [DW-1:0] dout_out_reg [2];
    logic          err_reg;

    logic [1:0] ch_src;     // master currently mapped onto each channel
    logic [1:0] ch_req;
    logic [1:0] ch_accept;
    logic [1:0] ch_done;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign ch_src[gi]    = map_reg ^ 1'(gi);
            assign ch_req[gi]    = m_mem[ch_src[gi]];
            // A completion in the same cycle frees the channel for a new request.
            assign ch_accept[gi] = ch_req[gi] & (~busy_reg[gi] | c_ready[gi]);
            assign ch_done[gi]   = busy_reg[gi] & c_ready[gi];

            // Channel state, owner and registered request forwarding.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_reg[gi]    <= 1'b0;
                    owner_reg[gi]   <= 1'b0;
                    mem_out_reg[gi] <= 1'b0;
                    rw_out_reg[gi]  <= 1'b0;
                    din_out_reg[gi] <= '0;
                    adr_out_reg[gi] <= '0;
                end else begin
                    mem_out_reg[gi] <= ch_accept[gi];
                    if (ch_accept[gi]) begin
                        busy_reg[gi]    <= 1'b1;
                        owner_reg[gi]   <= ch_src[gi];
                        rw_out_reg[gi]  <= m_rw[ch_src[gi]];
                        din_out_reg[gi] <= m_din[ch_src[gi]];
                        adr_out_reg[gi] <= m_adr[ch_src[gi]];
                    end else if (ch_done[gi]) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_master
            logic hit0;
            logic hit1;
            assign hit0 = ch_done[0] & (owner_reg[0] == 1'(gi));
            assign hit1 = ch_done[1] & (owner_reg[1] == 1'(gi));

            // Return completions to the master recorded at request time.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ready_out_reg[gi] <= 1'b0;
                    dout_out_reg[gi]  <= '0;
                end else begin
                    ready_out_reg[gi] <= hit0 | hit1;
                    if (hit0) begin
                        dout_out_reg[gi] <= c_dout[0];
                    end else if (hit1) begin
                        dout_out_reg[gi] <= c_dout[1];
                    end
                end
            end
        end
    endgenerate

    swap_state_t swap_state_reg;
    swap_state_t swap_state_next;
    logic        do_swap;
    logic        swap_pulse_reg;
    logic        swap_ack_reg;

    // Swap decision: only commit when nothing is in flight or arriving.
    always_comb begin
        swap_state_next = swap_state_reg;
        do_swap         = 1'b0;
        case (swap_state_reg)
            SW_STABLE: begin
                if (sel != map_reg) swap_state_next = SW_PENDING;
            end
            SW_PENDING: begin
                if (sel == map_reg) begin
                    swap_state_next = SW_STABLE;
                end else if ((busy_reg == 2'b00) && (m_mem == 2'b00) &&
                             (mem_out_reg == 2'b00)) begin
                    do_swap         = 1'b1;
                    swap_state_next = SW_STABLE;
                end
            end
            default: swap_state_next = SW_STABLE;
        endcase
    end

    // Mapping register, swap FSM state, ack delay line and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_state_reg <= SW_STABLE;
            map_reg        <= 1'b0;
            swap_pulse_reg <= 1'b0;
            swap_ack_reg   <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            swap_state_reg <= swap_state_next;
            swap_pulse_reg <= do_swap;
            swap_ack_reg   <= swap_pulse_reg;
            if (do_swap) map_reg <= sel;
            if (|(ch_req & ~ch_accept)) err_reg <= 1'b1;
        end
    end

    assign map_o     = map_reg;
    assign swap_ack  = swap_ack_reg;
    assign err_o     = err_reg;
    assign o_mem1    = mem_out_reg[0];
    assign o_mem2    = mem_out_reg[1];
    assign o_rw1     = rw_out_reg[0];
    assign o_rw2     = rw_out_reg[1];
    assign o_din1    = din_out_reg[0];
    assign o_din2    = din_out_reg[1];
    assign o_adr1    = adr_out_reg[0];
    assign o_adr2    = adr_out_reg[1];
    assign o_ready_A = ready_out_reg[0];
    assign o_ready_B = ready_out_reg[1];
    assign o_dout_A  = dout_out_reg[0];
    assign o_dout_B  = dout_out_reg[1];

endmodule
